// File: rtl/sub_seq_if.sv
// Operand/result bundle for the digit-serial subtractor.
// The requester drives start and the operands; the subtractor drives status and results.
interface sub_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C_wej;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Q;
    logic             C_wyj;
    logic             zero;
    logic             ovf;

    modport master (
        output start, A, B, C_wej,
        input  busy, done, Q, C_wyj, zero, ovf
    );

    modport slave (
        input  start, A, B, C_wej,
        output busy, done, Q, C_wyj, zero, ovf
    );
endinterface

// File: rtl/sub_seq.sv
// Digit-serial subtractor: Q = A - B - C_wej over WIDTH bits, DIGIT bits per clock,
// least significant digit first. Results and flags are registered and only change
// on the edge that finishes an operation.
module sub_seq #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic     clk,
    input  logic     rst_n,
    sub_seq_if.slave bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

    if (WIDTH < 2) begin : gen_bad_width
        $error("sub_seq: WIDTH must be at least 2");
    end
    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : gen_bad_digit
        $error("sub_seq: DIGIT must lie in 1..WIDTH and divide WIDTH exactly");
    end

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] aShift_q;
    logic [WIDTH-1:0] bShift_q;
    logic             borrow_q;
    logic [CNT_W-1:0] cnt_q;
    logic             aMsb_q;
    logic             bMsb_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             borrowOut_q;
    logic             zero_q;
    logic             ovf_q;

    logic [DIGIT:0]   digit_d;
    logic [WIDTH-1:0] aShift_d;
    logic [WIDTH-1:0] bShift_d;

    // One digit of the subtraction; the extra top bit is the borrow into the next digit.
    always_comb begin
        digit_d = {1'b0, aShift_q[DIGIT-1:0]}
                - {1'b0, bShift_q[DIGIT-1:0]}
                - {{DIGIT{1'b0}}, borrow_q};
    end

    // The minuend register doubles as the result shifter: difference digits enter at the
    // top as minuend digits leave at the bottom, so after STEPS shifts it holds Q.
    if (DIGIT == WIDTH) begin : gen_single_step
        assign aShift_d = digit_d[DIGIT-1:0];
        assign bShift_d = '0;
    end else begin : gen_multi_step
        assign aShift_d = {digit_d[DIGIT-1:0], aShift_q[WIDTH-1:DIGIT]};
        assign bShift_d = {{DIGIT{1'b0}}, bShift_q[WIDTH-1:DIGIT]};
    end

    // Control FSM and datapath registers: accept in IDLE, one digit per edge in RUN,
    // publish results and pulse done on the last digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            aShift_q    <= '0;
            bShift_q    <= '0;
            borrow_q    <= 1'b0;
            cnt_q       <= '0;
            aMsb_q      <= 1'b0;
            bMsb_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            borrowOut_q <= 1'b0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        aShift_q <= bus.A;
                        bShift_q <= bus.B;
                        borrow_q <= bus.C_wej;
                        aMsb_q   <= bus.A[WIDTH-1];
                        bMsb_q   <= bus.B[WIDTH-1];
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    aShift_q <= aShift_d;
                    bShift_q <= bShift_d;
                    borrow_q <= digit_d[DIGIT];
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        result_q    <= aShift_d;
                        borrowOut_q <= digit_d[DIGIT];
                        zero_q      <= (aShift_d == '0);
                        ovf_q       <= (aMsb_q != bMsb_q) && (aShift_d[WIDTH-1] != aMsb_q);
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.Q     = result_q;
    assign bus.C_wyj = borrowOut_q;
    assign bus.zero  = zero_q;
    assign bus.ovf   = ovf_q;
endmodule
